deskew_registers: RTL and testbench
===================================

# deskew_registers

Realigns the diagonally skewed result rows leaving the systolic array back into row-parallel words before they are written to the output buffer. Lane i of a row arrives i enabled cycles after lane 0; this block delays lane i by N-i registers, so all N lanes of a row leave together on one registered output. A small controller counts a programmed number of rows, gates `din_valid`, and signals completion. This is the inverse of the input-side `skew_registers`.

## Interface
- `DATA_WIDTH`, 16, width of one lane, signed.
- `N`, 4, number of lanes (array columns), N >= 2.
- `ROW_CNT_W`, 16, width of the row count.

- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  global advance; when low, all state holds.
- `start`  input  1  one-cycle pulse that begins a run; sampled in IDLE only.
- `num_rows`  input  ROW_CNT_W  rows in the run; latched on an accepted `start`.
- `din`  input  N x DATA_WIDTH  skewed lane inputs, as an unpacked array [N-1:0].
- `din_valid`  input  1  qualifies a row; presented in the same cycle as that row's lane 0.
- `dout`  output  N x DATA_WIDTH  aligned row, registered.
- `dout_valid`  output  1  one-cycle pulse per aligned row.
- `busy`  output  1  high in RUN.
- `done`  output  1  one-cycle pulse, coincident with the last `dout_valid` of a run.

## Operation
- Lane i passes through a shift chain of N-i registers. The last stage of every chain is the `dout` register.
- A valid chain of N stages tracks `din_valid` alongside lane 0. `din_valid` enters the chain only in RUN, and only while `accepted < num_rows`; otherwise a 0 enters.
- All chains shift only on edges where `en`=1.
- FSM states:
  - IDLE: `busy`=0. When `start`=1 and `num_rows` != 0, latch `num_rows`, clear `accepted` and `emitted`, and go to RUN. A `start` with `num_rows`=0 is ignored.
  - RUN: `busy`=1. `accepted` increments on each enabled edge that samples a gated `din_valid`. `emitted` increments on each `dout_valid`.
  - When `emitted` reaches `num_rows`, assert `done` in that cycle and return to IDLE on the next edge.
- `start` while in RUN is ignored.
- Data is not modified; no arithmetic is performed on lanes.
- Counter widths are ROW_CNT_W; no wrap is possible because counting stops at `num_rows`.

## Timing
- Reset values: every data register and `dout` = 0; `dout_valid`=0, `busy`=0, `done`=0; FSM = IDLE; both counters = 0.
- Latency: a row whose lane 0 is sampled on enabled edge E appears on `dout`, with `dout_valid`=1, after enabled edge E+N-1. That is N enabled edges in total, counting E.
- Lane i of the same row must be presented on enabled edge E+i.
- `dout_valid` is 1 only in the cycle immediately following an enabled edge that shifted a valid row out.
- When `en`=0: `dout` holds its value; `dout_valid`=0 and `done`=0 in the following cycle; stalled rows resume exactly where they stopped.
- A `start` accepted on a cycle where `en`=0 still moves the FSM to RUN; the controller itself is not gated by `en`.
- Back-to-back rows (`din_valid` high on every enabled edge) yield `dout_valid` high on consecutive cycles.
- Asserting `rst` mid-run clears all state immediately. Rows in flight are discarded and `done` is not issued.

## Configuration
- `DESKEW_ZERO_INVALID_EN`:
  - Defined: `dout` is forced to all zeros in every cycle where `dout_valid`=0.
  - Undefined: `dout` always shows the raw output registers, including stale or partial rows.

## Test plan
- Reset: assert `rst` with `en`=1 -> `dout`=0, `dout_valid`=0, `busy`=0 and `done`=0, held while `rst` is high.
- Single row, N=4: `start` with `num_rows`=1; lanes 0..3 = 1,2,3,4 fed on edges E..E+3 -> `dout`={1,2,3,4} with `dout_valid`=1 and `done`=1 in the cycle after edge E+3, then `busy`=0.
- Streaming: `num_rows`=3, rows {1,2,3,4}, {2,3,4,5}, {3,4,5,6} skewed back-to-back -> three consecutive `dout_valid` cycles with those exact rows; `done` on the third.
- Stall: drop `en` for 2 cycles in the middle of row 2 of the streaming case -> `dout_valid` gap of exactly 2 cycles, rows unchanged, `done` still on row 3.
- Over-feed and ignored start: `num_rows`=2, drive `din_valid` for 4 rows and pulse `start` during RUN -> exactly 2 `dout_valid` pulses, one `done`, FSM in IDLE.
- Mid-run reset: pulse `rst` after row 1 is accepted -> no `dout_valid` or `done` afterwards; a fresh `start` with `num_rows`=1 works normally. With `DESKEW_ZERO_INVALID_EN` defined, `dout`=0 whenever `dout_valid`=0.

Source files
------------

// File: rtl/deskew_registers.sv
// rtl/deskew_registers.sv - realigns diagonally skewed lanes into row-parallel words
// Optional DESKEW_ZERO_INVALID_EN: dout reads as zero whenever dout_valid is low.
module deskew_registers #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int ROW_CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [ROW_CNT_W-1:0]         num_rows,
  input  logic signed [DATA_WIDTH-1:0] din [N-1:0],
  input  logic                         din_valid,
  output logic signed [DATA_WIDTH-1:0] dout [N-1:0],
  output logic                         dout_valid,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [ROW_CNT_W-1:0] num_rows_q, num_rows_d;
  logic [ROW_CNT_W-1:0] accepted_q, accepted_d;
  logic [ROW_CNT_W-1:0] emitted_q, emitted_d;
  logic [N-1:0]         vld_q, vld_d;
  logic                 done_q, done_d;
  logic                 din_gated;

  logic signed [DATA_WIDTH-1:0] dout_raw [N-1:0];

  // Lane i waits N-i enabled edges; its final stage doubles as the dout register.
  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int DEPTH = N - i;
    logic signed [DATA_WIDTH-1:0] chain_q [DEPTH];
    logic signed [DATA_WIDTH-1:0] chain_d [DEPTH];

    always_comb begin
      chain_d = chain_q;
      if (en) begin
        chain_d[0] = din[i];
        for (int k = 1; k < DEPTH; k++) begin
          chain_d[k] = chain_q[k-1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < DEPTH; k++) begin
          chain_q[k] <= '0;
        end
      end else begin
        chain_q <= chain_d;
      end
    end

    assign dout_raw[i] = chain_q[DEPTH-1];
  end

  assign din_gated = (state_q == S_RUN) && din_valid && (accepted_q < num_rows_q);

  // The last valid stage clears on a stalled edge so each row pulses exactly once.
  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d[0] = din_gated;
      for (int k = 1; k < N; k++) begin
        vld_d[k] = vld_q[k-1];
      end
    end else begin
      vld_d[N-1] = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    accepted_d = accepted_q;
    emitted_d  = emitted_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (num_rows != '0)) begin
          state_d    = S_RUN;
          num_rows_d = num_rows;
          accepted_d = '0;
          emitted_d  = '0;
        end
      end
      S_RUN: begin
        if (en && din_gated) begin
          accepted_d = accepted_q + ROW_CNT_W'(1);
        end
        if (en && vld_q[N-2]) begin
          emitted_d = emitted_q + ROW_CNT_W'(1);
          done_d    = (emitted_q + ROW_CNT_W'(1)) == num_rows_q;
        end
        if (done_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_rows_q <= '0;
      accepted_q <= '0;
      emitted_q  <= '0;
      vld_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      accepted_q <= accepted_d;
      emitted_q  <= emitted_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
    end
  end

  assign dout_valid = vld_q[N-1];
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;

`ifdef DESKEW_ZERO_INVALID_EN
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dout[i] = dout_valid ? dout_raw[i] : '0;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dout[i] = dout_raw[i];
    end
  end
`endif

endmodule

// File: tb/tb_deskew_registers.sv
// tb/tb_deskew_registers.sv - scoreboard bench for deskew_registers
// Honours DESKEW_ZERO_INVALID_EN when the design is built with it.
module tb_deskew_registers;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int RW = 16;

  logic                 clk = 1'b0;
  logic                 rst, en, start, din_valid;
  logic [RW-1:0]        num_rows;
  logic signed [DW-1:0] din  [N-1:0];
  logic signed [DW-1:0] dout [N-1:0];
  logic                 dout_valid, busy, done;

  always #5 clk = ~clk;

  deskew_registers #(.DATA_WIDTH(DW), .N(N), .ROW_CNT_W(RW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .num_rows(num_rows),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [N*DW-1:0] data;
    int              eidx;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ecount = 0;
  int   done_seen = 0;
  bit   last_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Index of enabled edges; a row whose lane 0 rides edge E is due after edge E+N-1.
  always @(posedge clk) begin
    last_en = !rst && en;
    if (last_en) ecount++;
  end

  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (rst) begin
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      for (int i = 0; i < N; i++) chk("rst_dout", dout[i], 0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].eidx < ecount - 1) begin
        chk("row_missed_edge", ecount - 1, exp_q[0].eidx);
        void'(exp_q.pop_front());
      end
      exp_v = last_en && exp_q.size() > 0 && exp_q[0].eidx == ecount - 1;
      chk("dout_valid", dout_valid, exp_v);
      if (done) done_seen++;
      if (exp_v) begin
        e = exp_q.pop_front();
        if (dout_valid) begin
          for (int i = 0; i < N; i++) chk("dout_lane", dout[i], $signed(e.data[i*DW +: DW]));
          chk("done_on_row", done, e.last);
        end
      end else begin
        chk("done_idle", done, 0);
`ifdef DESKEW_ZERO_INVALID_EN
        for (int i = 0; i < N; i++) chk("dout_zero_invalid", dout[i], 0);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_din();
    for (int i = 0; i < N; i++) din[i] = DW'($urandom);
  endtask

  task automatic idle_cycles(input int n, input bit noise);
    for (int c = 0; c < n; c++) begin
      en        = 1'($urandom);
      start     = 1'b0;
      din_valid = noise ? 1'($urandom) : 1'b0;
      rand_din();
      step();
    end
  endtask

  task automatic do_start(input int nr);
    start     = 1'b1;
    num_rows  = RW'(nr);
    din_valid = 1'b0;
    en        = 1'($urandom);
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_case(input int nr_in, input int nslots, input int valid_pct,
                          input int en_pct, input bit pattern, input int stall_t,
                          input bit mid_start);
    logic [N*DW-1:0] sd[$];
    bit              sv[$];
    logic [N*DW-1:0] row;
    int              nr, vcount, acc, t, guard, stall_cnt, d0;
    bit              cur_en;
    vcount = 0;
    for (int s = 0; s < nslots; s++) begin
      sv.push_back($urandom_range(1, 100) <= valid_pct);
      if (sv[s]) vcount++;
      for (int i = 0; i < N; i++) row[i*DW +: DW] = pattern ? DW'(s + i + 1) : DW'($urandom);
      sd.push_back(row);
    end
    if (vcount == 0) begin
      sv[0]  = 1'b1;
      vcount = 1;
    end
    nr = (nr_in > vcount) ? vcount : nr_in;
    d0 = done_seen;
    acc = 0; t = 0; guard = 0; stall_cnt = 0;
    do_start(nr);
    while (t < nslots + N - 1 && guard < 5000) begin
      guard++;
      if (t == stall_t && stall_cnt < 2) begin
        cur_en = 1'b0;
        stall_cnt++;
      end else begin
        cur_en = $urandom_range(1, 100) <= en_pct;
      end
      en        = cur_en;
      start     = mid_start && (t == 1);
      if (start) num_rows = RW'($urandom_range(1, 9));
      din_valid = (t < nslots) ? sv[t] : 1'b0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < nslots) din[i] = $signed(sd[t-i][i*DW +: DW]);
        else din[i] = DW'($urandom);
      end
      if (cur_en && din_valid && acc < nr) begin
        exp_q.push_back('{data: sd[t], eidx: ecount + N - 1, last: (acc == nr - 1)});
        acc++;
      end
      step();
      start = 1'b0;
      if (cur_en) t++;
    end
    din_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() > 0 || busy) && guard < 300) begin
      guard++;
      en = $urandom_range(1, 100) <= en_pct;
      rand_din();
      step();
    end
    chk("drain_pending_rows", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    chk("done_count", done_seen - d0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b1; din_valid = 1'b1; num_rows = RW'(5);
    rand_din();
    repeat (3) step();
    rst = 1'b0; start = 1'b0; din_valid = 1'b0;
    idle_cycles(3, 1'b1);

    start = 1'b1; num_rows = '0; en = 1'b1;
    step();
    start = 1'b0;
    chk("zero_rows_start_ignored", busy, 0);
    idle_cycles(2, 1'b1);

    run_case(1, 1, 100, 100, 1'b1, -1, 1'b0);
    idle_cycles(3, 1'b1);
    run_case(3, 3, 100, 100, 1'b1, -1, 1'b0);
    idle_cycles(3, 1'b0);
    run_case(3, 3, 100, 100, 1'b1, 2, 1'b0);
    idle_cycles(3, 1'b1);
    run_case(2, 4, 100, 100, 1'b0, -1, 1'b1);
    idle_cycles(3, 1'b1);

    begin
      int d0;
      d0 = done_seen;
      do_start(3);
      en = 1'b1; din_valid = 1'b1;
      rand_din();
      step();
      rand_din();
      step();
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      idle_cycles(12, 1'b1);
      chk("reset_busy", busy, 0);
      chk("reset_no_done", done_seen - d0, 0);
    end
    run_case(1, 1, 100, 100, 1'b1, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      idle_cycles($urandom_range(1, 4), 1'b1);
      run_case($urandom_range(1, 6), $urandom_range(4, 10), 70, 75, 1'b0, -1, 1'($urandom));
    end

    idle_cycles(4, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
